vram_write_scheduler: RTL
=========================

Name: vram_write_scheduler

Overview:
- Buffers CPU-side VRAM write requests in a FIFO.
- Drains them into the GPU's VRAM write port only while the video timing reports the write window (writable) open.
- Sits between the CPU bus decode and the GPU VRAM interface. It lets the CPU post writes at any time instead of polling in_vblank.
- Reports queue depth and sticky status (window missed, bad target) for software.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256.
- ADDR_WIDTH, 12, VRAM address width; equals `VRAM_ADDR_WIDTH at instantiation.

Ports:
- gpu_clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- writable  in  1  write window from video timing; level, synchronous to gpu_clk.
- req_valid  in  1  requester has a write.
- req_ready  out  1  scheduler can accept; transfer when req_valid&&req_ready at an edge.
- req_addr  in  ADDR_WIDTH  VRAM address.
- req_data  in  8  write data.
- req_target  in  3  0=pmf 1=pmb 2=ntbl 3=obm 4=txbl; 5..7 illegal.
- vram_we  out  1  write strobe to GPU (vram write_enable & SELECT_vram).
- vram_addr  out  ADDR_WIDTH  address for the current issue.
- vram_data  out  8  data for the current issue.
- sel_pmf, sel_pmb, sel_ntbl, sel_obm, sel_txbl  out  1 each  one-hot region select, valid when vram_we=1, else 0.
- pending  out  $clog2(DEPTH)+1  FIFO occupancy.
- window_missed  out  1  sticky: writable fell while pending!=0.
- bad_target  out  1  sticky: illegal req_target accepted.
- drained  out  1  1-cycle pulse: FIFO became empty during an open window.
- clr_status  in  1  clears window_missed and bad_target.

Behaviour:
- Reset: FIFO empty, pending=0, all sticky flags 0, drained=0, state=CLOSED.
- Reset outputs: vram_we=0, all sel_*=0, vram_addr=0, vram_data=0, req_ready=1.
- Reset mid-operation discards queued entries; a strobe in the reset cycle is still combinational but no entry is retired.
- FIFO:
  - Register array with rd/wr pointers of width $clog2(DEPTH) that wrap modulo DEPTH.
  - Count 0..DEPTH.
  - req_ready = (pending != DEPTH).
- Ingress:
  - Legal targets are pushed.
  - Illegal targets (5..7) are handshaken (req_ready honoured), not stored, and set bad_target at the next edge.
- States:
  - CLOSED (writable=0).
  - DRAIN (writable=1, pending!=0).
  - IDLE_OPEN (writable=1, pending=0).
  - Transitions are evaluated each edge from the next-cycle writable and pending values.
- Issue (combinational):
  - vram_we = writable && pending!=0.
  - vram_addr/vram_data/sel_* come from the FIFO head.
  - The head is retired at the edge ending a cycle with vram_we=1.
  - Maximum one issue per cycle.
  - If writable is 0, vram_we is 0 the same cycle and nothing is lost.
- Latency: an entry accepted at edge E is issuable at the earliest in the cycle after E.
  - Entries are issued in strict acceptance order.
- Simultaneous push and retire: both occur; pending unchanged.
  - At pending=DEPTH, a retire in the same cycle does not raise req_ready until the next cycle.
- window_missed: set at the edge where writable goes 1→0 while pending!=0 after that edge's retire.
- drained: asserted for the cycle following the edge where pending goes 1→0 via a retire.
- Flag priority: clr_status has priority over a same-edge set.

Optional Feature:
- Macro VRAM_WSCHED_BYPASS_EN.
- Defined: when writable=1, pending=0 and a legal request handshakes, it is issued combinationally that same cycle (vram_we=1 with req_addr/req_data/target) and is not stored. pending stays 0 and drained does not pulse.
- Undefined: every request goes through the FIFO, with a minimum latency of one cycle.

Test Plan:
- Reset, then writable=0 and push 3 writes (0x010/0xAA/pmf, 0x011/0xBB/ntbl, 0x012/0xCC/obm) → pending=3, vram_we=0; raise writable → three consecutive cycles of vram_we=1 in order with matching sel_*, then pending=0 and drained pulses once.
- writable=0, push DEPTH=16 writes → req_ready=0 at pending=16, 17th held; raise writable for 1 cycle → one issue and pending=15; req_ready=1 the following cycle.
- writable=1 with 5 queued; drop writable after 2 issues → window_missed=1, pending=3; next window issues the remaining 3 in order; clr_status → window_missed=0.
- Push with req_target=6 → accepted, never issued, bad_target=1, pending unchanged.
- Push and retire in the same cycle at pending=4 → pending stays 4; assert rst with pending=4 → pending=0, vram_we=0 next cycle.
- With VRAM_WSCHED_BYPASS_EN: writable=1, empty, push 0x123/0x5A/pmb → vram_we=1 in the handshake cycle, sel_pmb=1, pending stays 0.
- Without VRAM_WSCHED_BYPASS_EN, same stimulus → vram_we=1 one cycle later.

Source files
------------

// File: rtl/vram_write_scheduler.sv
// Posted-write FIFO between CPU bus decode and the GPU VRAM write port; drains only while the
// video write window is open. Optional same-cycle bypass of an empty queue: VRAM_WSCHED_BYPASS_EN.
module vram_write_scheduler #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                     gpu_clk,
  input  logic                     rst,
  input  logic                     writable,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  logic [7:0]               req_data,
  input  logic [2:0]               req_target,
  output logic                     vram_we,
  output logic [ADDR_WIDTH-1:0]    vram_addr,
  output logic [7:0]               vram_data,
  output logic                     sel_pmf,
  output logic                     sel_pmb,
  output logic                     sel_ntbl,
  output logic                     sel_obm,
  output logic                     sel_txbl,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     window_missed,
  output logic                     bad_target,
  output logic                     drained,
  input  logic                     clr_status
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_WIDTH + 8 + 3;
  localparam logic [CW-1:0] ZERO_C  = CW'(0);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic [1:0] {
    ST_CLOSED    = 2'd0,
    ST_DRAIN     = 2'd1,
    ST_IDLE_OPEN = 2'd2
  } state_t;

  state_t                r_state;
  logic [EW-1:0]         r_mem [DEPTH];
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_wr_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_window_missed;
  logic                  r_bad_target;
  logic                  r_drained;

  logic                  w_handshake;
  logic                  w_legal;
  logic                  w_fifo_issue;
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_retire;
  logic [CW-1:0]         w_count_next;
  logic [EW-1:0]         w_head;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_data;
  logic [2:0]            w_tgt;
  logic [4:0]            w_sel;

  assign w_handshake  = req_valid && req_ready;
  assign w_legal      = (req_target <= 3'd4);
  assign w_fifo_issue = writable && (r_count != ZERO_C);
  assign w_head       = r_mem[r_rd_ptr];

`ifdef VRAM_WSCHED_BYPASS_EN
  // An empty queue in an open window forwards a legal request straight to the port.
  assign w_bypass = writable && (r_count == ZERO_C) && w_handshake && w_legal;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push   = w_handshake && w_legal && !w_bypass;
  assign w_retire = w_fifo_issue;

  // Occupancy after this edge's push and retire.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_retire})
      2'b10:   w_count_next = r_count + ONE_C;
      2'b01:   w_count_next = r_count - ONE_C;
      default: w_count_next = r_count;
    endcase
  end

  // Issue source select: FIFO head, bypassed request, or an idle all-zero port.
  always_comb begin
    w_we   = 1'b0;
    w_addr = {ADDR_WIDTH{1'b0}};
    w_data = 8'h00;
    w_tgt  = 3'd0;
    if (w_fifo_issue) begin
      w_we   = 1'b1;
      w_addr = w_head[ADDR_WIDTH-1:0];
      w_data = w_head[ADDR_WIDTH+7:ADDR_WIDTH];
      w_tgt  = w_head[EW-1:EW-3];
    end else if (w_bypass) begin
      w_we   = 1'b1;
      w_addr = req_addr;
      w_data = req_data;
      w_tgt  = req_target;
    end else begin
      w_we   = 1'b0;
      w_addr = {ADDR_WIDTH{1'b0}};
      w_data = 8'h00;
      w_tgt  = 3'd0;
    end
  end

  // One-hot region decode, silent whenever no write is issued.
  always_comb begin
    w_sel = 5'b00000;
    if (w_we) begin
      case (w_tgt)
        3'd0:    w_sel = 5'b00001;
        3'd1:    w_sel = 5'b00010;
        3'd2:    w_sel = 5'b00100;
        3'd3:    w_sel = 5'b01000;
        3'd4:    w_sel = 5'b10000;
        default: w_sel = 5'b00000;
      endcase
    end else begin
      w_sel = 5'b00000;
    end
  end

  // Entry storage; contents are meaningless outside the rd..wr window, so no reset.
  always_ff @(posedge gpu_clk) begin
    if (w_push && !rst) begin
      r_mem[r_wr_ptr] <= {req_target, req_data, req_addr};
    end
  end

  // Pointers, occupancy and status flags.
  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      r_rd_ptr        <= {PW{1'b0}};
      r_wr_ptr        <= {PW{1'b0}};
      r_count         <= ZERO_C;
      r_window_missed <= 1'b0;
      r_bad_target    <= 1'b0;
      r_drained       <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_retire) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_count   <= w_count_next;
      r_drained <= w_retire && (r_count == ONE_C) && !w_push;
      // A window that was open last cycle and is shut now, with work left behind.
      if (clr_status) begin
        r_window_missed <= 1'b0;
      end else if ((r_state != ST_CLOSED) && !writable && (w_count_next != ZERO_C)) begin
        r_window_missed <= 1'b1;
      end
      if (clr_status) begin
        r_bad_target <= 1'b0;
      end else if (w_handshake && !w_legal) begin
        r_bad_target <= 1'b1;
      end
    end
  end

  // Window state tracks the sampled window level and the post-edge occupancy.
  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      r_state <= ST_CLOSED;
    end else begin
      case (r_state)
        ST_CLOSED, ST_DRAIN, ST_IDLE_OPEN: begin
          if (!writable) begin
            r_state <= ST_CLOSED;
          end else if (w_count_next != ZERO_C) begin
            r_state <= ST_DRAIN;
          end else begin
            r_state <= ST_IDLE_OPEN;
          end
        end
        default: r_state <= ST_CLOSED;
      endcase
    end
  end

  assign req_ready     = (r_count != DEPTH_C);
  assign vram_we       = w_we;
  assign vram_addr     = w_addr;
  assign vram_data     = w_data;
  assign sel_pmf       = w_sel[0];
  assign sel_pmb       = w_sel[1];
  assign sel_ntbl      = w_sel[2];
  assign sel_obm       = w_sel[3];
  assign sel_txbl      = w_sel[4];
  assign pending       = r_count;
  assign window_missed = r_window_missed;
  assign bad_target    = r_bad_target;
  assign drained       = r_drained;

endmodule
